// File: rtl/sump_cmd_decoder.sv
// ============================================================================
// Module   : sump_cmd_decoder
// Brief    : SUMP/OLS host command assembler (1-byte short / 5-byte long).
//            Optional inter-byte timeout for long commands: CMD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sump_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        extReset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_data,
  output logic        cmd_long,
  output logic        soft_reset,
  output logic        arm,
  output logic        query_id,
  output logic        query_metadata,
  output logic        xon,
  output logic        xoff,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [7:0]  op_sh_q;
  logic [23:0] data_sh_q;   // first three payload bytes; the fourth comes straight from rx_data
  logic        cmd_valid_q;
  logic [7:0]  cmd_opcode_q;
  logic [31:0] cmd_data_q;
  logic        cmd_long_q;
  logic [5:0]  pulse_q;     // {soft_reset, arm, query_id, query_metadata, xon, xoff}
  logic        busy_q;
  logic        timeout_err_q;

`ifdef CMD_TIMEOUT_EN
  localparam logic [23:0] C_TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] tmr_q;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clock) begin
    if (extReset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 2'd0;
      op_sh_q       <= 8'h00;
      data_sh_q     <= 24'h0;
      cmd_valid_q   <= 1'b0;
      cmd_opcode_q  <= 8'h00;
      cmd_data_q    <= 32'h0;
      cmd_long_q    <= 1'b0;
      pulse_q       <= 6'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmr_q         <= 24'h0;
`endif
    end else begin
      cmd_valid_q   <= 1'b0;
      pulse_q       <= 6'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            if (!rx_data[7]) begin
              cmd_valid_q  <= 1'b1;
              cmd_opcode_q <= rx_data;
              cmd_data_q   <= 32'h0;
              cmd_long_q   <= 1'b0;
              pulse_q      <= {rx_data == 8'h00, rx_data == 8'h01, rx_data == 8'h02,
                               rx_data == 8'h04, rx_data == 8'h11, rx_data == 8'h13};
            end else begin
              op_sh_q <= rx_data;
              cnt_q   <= 2'd0;
              busy_q  <= 1'b1;
              state_q <= ST_DATA;
`ifdef CMD_TIMEOUT_EN
              tmr_q   <= 24'h0;
`endif
            end
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
`ifdef CMD_TIMEOUT_EN
            tmr_q <= 24'h0;
`endif
            cnt_q <= cnt_q + 2'd1;
            case (cnt_q)
              2'd0: data_sh_q[7:0]   <= rx_data;
              2'd1: data_sh_q[15:8]  <= rx_data;
              2'd2: data_sh_q[23:16] <= rx_data;
              default: begin
                cmd_valid_q  <= 1'b1;
                cmd_opcode_q <= op_sh_q;
                cmd_data_q   <= {rx_data, data_sh_q};
                cmd_long_q   <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= ST_IDLE;
              end
            endcase
          end
`ifdef CMD_TIMEOUT_EN
          else if (tmr_q == C_TMO_LAST) begin
            // Expiry on an idle cycle drops the partial command entirely.
            tmr_q         <= 24'h0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + 24'h1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid      = cmd_valid_q;
  assign cmd_opcode     = cmd_opcode_q;
  assign cmd_data       = cmd_data_q;
  assign cmd_long       = cmd_long_q;
  assign soft_reset     = pulse_q[5];
  assign arm            = pulse_q[4];
  assign query_id       = pulse_q[3];
  assign query_metadata = pulse_q[2];
  assign xon            = pulse_q[1];
  assign xoff           = pulse_q[0];
  assign busy           = busy_q;
  assign timeout_err    = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sump_cmd_decoder.sv
// ============================================================================
// Module   : tb_sump_cmd_decoder
// Brief    : Directed bench for sump_cmd_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sump_cmd_decoder;

  logic        clock;
  logic        extReset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        cmd_long;
  logic        soft_reset;
  logic        arm;
  logic        query_id;
  logic        query_metadata;
  logic        xon;
  logic        xoff;
  logic        busy;
  logic        timeout_err;
  logic [5:0]  pulses;

  int total;
  int bad;

  sump_cmd_decoder #(.TIMEOUT_CYCLES(10)) dut (
    .clock(clock), .extReset(extReset), .rx_valid(rx_valid), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_data(cmd_data),
    .cmd_long(cmd_long), .soft_reset(soft_reset), .arm(arm), .query_id(query_id),
    .query_metadata(query_metadata), .xon(xon), .xoff(xoff), .busy(busy),
    .timeout_err(timeout_err)
  );

  assign pulses = {soft_reset, arm, query_id, query_metadata, xon, xoff};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one cycle; returns at the negedge after it was sampled.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    logic busy_at;
    total    = 0;
    bad      = 0;
    extReset = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    chk("rst_valid",  32'(cmd_valid),   32'h0);
    chk("rst_opcode", 32'(cmd_opcode),  32'h0);
    chk("rst_data",   cmd_data,         32'h0);
    chk("rst_long",   32'(cmd_long),    32'h0);
    chk("rst_pulses", 32'(pulses),      32'h0);
    chk("rst_busy",   32'(busy),        32'h0);
    chk("rst_tmo",    32'(timeout_err), 32'h0);
    extReset = 1'b0;
    idle(1);

    // Short command: query_metadata
    send(8'h04);
    chk("qm_valid",  32'(cmd_valid),  32'h1);
    chk("qm_pulses", 32'(pulses),     32'h04);
    chk("qm_opcode", 32'(cmd_opcode), 32'h04);
    chk("qm_long",   32'(cmd_long),   32'h0);
    chk("qm_data",   cmd_data,        32'h0);
    chk("qm_busy",   32'(busy),       32'h0);
    idle(1);
    chk("qm_valid_drop", 32'(cmd_valid),  32'h0);
    chk("qm_pulse_drop", 32'(pulses),     32'h0);
    chk("qm_hold",       32'(cmd_opcode), 32'h04);

    // Long command on consecutive cycles
    send(8'hC0);
    chk("lg_busy0", 32'(busy), 32'h1);
    chk("lg_nov0",  32'(cmd_valid), 32'h0);
    send(8'h78);
    chk("lg_busy1", 32'(busy), 32'h1);
    send(8'h56);
    chk("lg_busy2", 32'(busy), 32'h1);
    chk("lg_stable", cmd_data, 32'h0);
    send(8'h34);
    chk("lg_busy3", 32'(busy), 32'h1);
    chk("lg_nov3",  32'(cmd_valid), 32'h0);
    send(8'h12);
    chk("lg_valid",  32'(cmd_valid),  32'h1);
    chk("lg_opcode", 32'(cmd_opcode), 32'hC0);
    chk("lg_data",   cmd_data,        32'h12345678);
    chk("lg_long",   32'(cmd_long),   32'h1);
    chk("lg_pulses", 32'(pulses),     32'h0);
    chk("lg_busy",   32'(busy),       32'h0);
    idle(2);

    // Opcode-like bytes inside a payload
    send(8'h81);
    send(8'h00);
    chk("emb_v0", 32'({cmd_valid, pulses}), 32'h0);
    send(8'h04);
    chk("emb_v1", 32'({cmd_valid, pulses}), 32'h0);
    send(8'h80);
    chk("emb_v2", 32'({cmd_valid, pulses}), 32'h0);
    send(8'h01);
    chk("emb_valid",  32'(cmd_valid),  32'h1);
    chk("emb_data",   cmd_data,        32'h01800400);
    chk("emb_opcode", 32'(cmd_opcode), 32'h81);
    chk("emb_pulses", 32'(pulses),     32'h0);
    idle(1);

    // Reset in the middle of a long command
    send(8'h82);
    send(8'hAA);
    send(8'hBB);
    extReset = 1'b1;
    idle(1);
    extReset = 1'b0;
    chk("mr_valid", 32'(cmd_valid), 32'h0);
    chk("mr_busy",  32'(busy),      32'h0);
    chk("mr_data",  cmd_data,       32'h0);
    chk("mr_long",  32'(cmd_long),  32'h0);
    send(8'h02);
    chk("mr_qid_valid",  32'(cmd_valid),  32'h1);
    chk("mr_qid_pulses", 32'(pulses),     32'h08);
    chk("mr_qid_opcode", 32'(cmd_opcode), 32'h02);
    chk("mr_qid_busy",   32'(busy),       32'h0);
    idle(1);

    // Five soft resets, gaps 0/3/0/3 cycles
    send(8'h00);
    chk("sr1", 32'({cmd_valid, pulses}), 32'h60);
    send(8'h00);
    chk("sr2", 32'({cmd_valid, pulses}), 32'h60);
    idle(3);
    chk("sr_gap", 32'({cmd_valid, pulses}), 32'h0);
    send(8'h00);
    chk("sr3", 32'({cmd_valid, pulses}), 32'h60);
    send(8'h00);
    chk("sr4", 32'({cmd_valid, pulses}), 32'h60);
    idle(3);
    send(8'h00);
    chk("sr5", 32'({cmd_valid, pulses}), 32'h60);
    idle(1);

    // Remaining dedicated and unknown short opcodes
    send(8'h01);
    chk("arm", 32'({cmd_valid, pulses}), 32'h50);
    send(8'h13);
    chk("xoff", 32'({cmd_valid, pulses}), 32'h41);
    send(8'h7F);
    chk("unk", 32'({cmd_valid, pulses}), 32'h40);
    chk("unk_opcode", 32'(cmd_opcode), 32'h7F);
    idle(1);

    // Long command directly followed by a short one
    send(8'hC1);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    chk("bb_long_valid", 32'(cmd_valid), 32'h1);
    chk("bb_long_data",  cmd_data,       32'h04030201);
    send(8'h11);
    chk("bb_xon",      32'({cmd_valid, pulses}), 32'h42);
    chk("bb_xon_long", 32'(cmd_long), 32'h0);
    chk("bb_xon_data", cmd_data,      32'h0);
    idle(1);

`ifdef CMD_TIMEOUT_EN
    send(8'h83);
    send(8'h11);
    seen    = 1'b0;
    busy_at = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      if (timeout_err) begin
        seen    = 1'b1;
        busy_at = busy;
      end
    end
    chk("tmo_seen", 32'(seen),    32'h1);
    chk("tmo_busy", 32'(busy_at), 32'h0);
    idle(1);
    chk("tmo_pulse_width", 32'(timeout_err), 32'h0);
    send(8'h11);
    chk("tmo_xon", 32'({cmd_valid, pulses}), 32'h42);
    chk("tmo_xon_long", 32'(cmd_long), 32'h0);
`else
    seen    = 1'b0;
    busy_at = 1'b0;
    send(8'h83);
    send(8'h11);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (timeout_err) seen = 1'b1;
    end
    busy_at = busy;
    chk("notmo_err",  32'(seen),    32'h0);
    chk("notmo_busy", 32'(busy_at), 32'h1);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    chk("notmo_valid", 32'(cmd_valid), 32'h1);
    chk("notmo_data",  cmd_data,       32'h44332211);
    chk("notmo_op",    32'(cmd_opcode), 32'h83);
`endif
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
